// File: rtl/fetch_aligner.sv
// fetch_aligner: fetches 32-bit words from program memory into a small
// halfword buffer and hands complete instructions to decode.
// Optional feature macro: COMPRESSED_EN enables RV32C realignment (16-bit
// instructions, halfword-granular redirects). Without it every instruction
// is 32-bit and all addresses are word aligned.
module fetch_aligner #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int unsigned BUF_HW    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_compressed
);

`ifdef COMPRESSED_EN
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFE;
`else
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
`endif
  // A new word may be requested only if it is guaranteed to fit on arrival.
  localparam logic [3:0] FILL_LIMIT = 4'(BUF_HW - 2);

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & PC_MASK;
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t      state_r, state_s;
  logic [31:0] fetch_pc_r, instr_pc_r;
  logic [15:0] hw_r    [4];
  logic [15:0] hw_s    [4];
  logic [15:0] shift_s [4];
  logic [2:0]  count_r, count_s, pop_s, base_s;
  logic        inflight_r;
  logic        head_wide_s, valid_s, handshake_s, req_s;
  logic [3:0]  occupancy_s;

`ifdef COMPRESSED_EN
  assign head_wide_s = (hw_r[0][1:0] == 2'b11);
`else
  assign head_wide_s = 1'b1;
`endif

  // Head decode: instruction completeness, handshake and pop amount.
  always_comb begin
    valid_s     = head_wide_s ? (count_r >= 3'd2) : (count_r >= 3'd1);
    handshake_s = valid_s & instr_ready;
    if (handshake_s) begin
      pop_s = head_wide_s ? 3'd2 : 3'd1;
    end else begin
      pop_s = 3'd0;
    end
    occupancy_s = {1'b0, count_r} + (inflight_r ? 4'd2 : 4'd0);
  end

  // Request issue: throttled in RUN, unconditional in FLUSH to restart the new path.
  always_comb begin
    req_s = 1'b0;
    case (state_r)
      IDLE:    req_s = 1'b0;
      RUN:     req_s = (occupancy_s <= FILL_LIMIT);
      FLUSH:   req_s = 1'b1;
      default: req_s = 1'b0;
    endcase
  end

  // Next-state logic; a redirect always restarts through FLUSH.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = redirect_valid ? FLUSH : RUN;
      RUN:     state_s = redirect_valid ? FLUSH : RUN;
      FLUSH:   state_s = redirect_valid ? FLUSH : RUN;
      default: state_s = IDLE;
    endcase
  end

  // Buffer update: pop from the head, then append the arriving word behind the survivors.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      shift_s[i] = 16'h0000;
      hw_s[i]    = 16'h0000;
    end
    case (pop_s)
      3'd0: begin
        for (int i = 0; i < 4; i++) begin
          shift_s[i] = hw_r[i];
        end
      end
      3'd1: begin
        shift_s[0] = hw_r[1];
        shift_s[1] = hw_r[2];
        shift_s[2] = hw_r[3];
      end
      3'd2: begin
        shift_s[0] = hw_r[2];
        shift_s[1] = hw_r[3];
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          shift_s[i] = hw_r[i];
        end
      end
    endcase
    base_s  = count_r - pop_s;
    count_s = 3'd0;
    if (redirect_valid) begin
      count_s = 3'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        hw_s[i] = (inflight_r && (3'(i) == base_s))         ? mem_rdata[15:0]  :
                  (inflight_r && (3'(i) == base_s + 3'd1))  ? mem_rdata[31:16] :
                  shift_s[i];
      end
      count_s = base_s + (inflight_r ? 3'd2 : 3'd0);
    end
  end

  // State, program counters, buffer and in-flight tracking registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      fetch_pc_r <= align_pc(BOOT_ADDR);
      instr_pc_r <= align_pc(BOOT_ADDR);
      count_r    <= 3'd0;
      inflight_r <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        hw_r[i] <= 16'h0000;
      end
    end else begin
      state_r <= state_s;
      if (redirect_valid) begin
        fetch_pc_r <= align_pc(redirect_pc);
      end else if (req_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
      if (redirect_valid) begin
        instr_pc_r <= align_pc(redirect_pc);
      end else if (handshake_s) begin
        instr_pc_r <= instr_pc_r + (head_wide_s ? 32'd4 : 32'd2);
      end else begin
        instr_pc_r <= instr_pc_r;
      end
      count_r    <= count_s;
      // A response belonging to the abandoned path must never be pushed.
      inflight_r <= req_s & ~redirect_valid;
      for (int i = 0; i < 4; i++) begin
        hw_r[i] <= hw_s[i];
      end
    end
  end

  assign mem_req          = req_s;
  assign mem_addr         = align_pc(fetch_pc_r);
  assign instr_valid      = valid_s;
  assign instr            = valid_s ? (head_wide_s ? {hw_r[1], hw_r[0]} : {16'h0000, hw_r[0]})
                                    : 32'h0000_0000;
  assign instr_pc         = instr_pc_r;
  assign instr_compressed = valid_s & ~head_wide_s;

endmodule

// File: tb/tb_fetch_aligner.sv
// Self-checking bench for fetch_aligner: a halfword memory model answers
// requests, a behavioural model predicts the instruction stream from the
// memory image and redirect history, plus literal checks of known sequences.
module tb_fetch_aligner;

  localparam logic [31:0] BOOT = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n, mem_req, redirect_valid, instr_valid, instr_ready, instr_compressed;
  logic [31:0] mem_addr, mem_rdata, redirect_pc, instr, instr_pc;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mem16 [0:127];
  logic [31:0] log_pc [$];
  logic [32:0] log_ins [$];

  fetch_aligner #(.BOOT_ADDR(BOOT), .BUF_HW(4)) dut (
    .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_compressed(instr_compressed)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    return mem16[a[7:1]];
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
`ifdef COMPRESSED_EN
    return {a[31:1], 1'b0};
`else
    return {a[31:2], 2'b00};
`endif
  endfunction

  // Expected {compressed, instr} for an instruction starting at byte address pc.
  function automatic logic [32:0] exp_at(input logic [31:0] pc);
    logic [15:0] h0, h1;
    h0 = hw_at(pc);
    h1 = hw_at(pc + 32'd2);
`ifdef COMPRESSED_EN
    if (h0[1:0] != 2'b11) return {1'b1, 16'h0000, h0};
`endif
    return {1'b0, h1, h0};
  endfunction

  function automatic logic [31:0] log_pc_at(input int i);
    if (i < log_pc.size()) return log_pc[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [32:0] log_ins_at(input int i);
    if (i < log_ins.size()) return log_ins[i];
    return 33'h1_DEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: response one cycle after the request, junk otherwise.
  always @(posedge clk) begin
    if (mem_req) mem_rdata <= {hw_at(mem_addr + 32'd2), hw_at(mem_addr)};
    else         mem_rdata <= $urandom;
  end

  // Per-cycle compare against the behavioural model.
  initial begin : compare_proc
    logic [31:0] exp_pc;
    logic [32:0] e;
    logic        hold;
    logic [65:0] held;
    int          idle_cnt;
    exp_pc = align(BOOT); hold = 1'b0; held = '0; idle_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        check("reset_outputs", {mem_req, instr_valid, instr_compressed, mem_addr, instr, instr_pc},
              {3'b000, BOOT, 32'h0000_0000, BOOT});
        exp_pc = align(BOOT); hold = 1'b0; idle_cnt = 0;
      end else begin
        if (hold) check("hold_stable", {instr_valid, instr_pc, instr, instr_compressed}, held);
        if (mem_req) check("mem_addr_align", mem_addr, align(mem_addr));
        if (instr_valid) begin
          e = exp_at(exp_pc);
          check("instr_pc", instr_pc, exp_pc);
          check("instr_word", {instr_compressed, instr}, e);
          idle_cnt = 0;
        end else begin
          e = exp_at(exp_pc);
          idle_cnt++;
          if (idle_cnt > 12) begin
            n_cmp++; n_bad++;
            $display("FAIL liveness: %0d cycles without instr_valid, expected at most 12", idle_cnt);
            idle_cnt = 0;
          end
        end
        hold = instr_valid && !instr_ready && !redirect_valid;
        held = {instr_valid, instr_pc, instr, instr_compressed};
        if (instr_valid && instr_ready) begin
          log_pc.push_back(instr_pc);
          log_ins.push_back({instr_compressed, instr});
          exp_pc = exp_pc + (e[32] ? 32'd2 : 32'd4);
        end
        if (redirect_valid) exp_pc = align(redirect_pc);
      end
    end
  end

  task automatic wait_log(input int n, input string name);
    int k;
    k = 0;
    while (log_pc.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (log_pc.size() < n) begin
      n_bad++;
      $display("FAIL %s: timeout with %0d handshakes, expected %0d", name, log_pc.size(), n);
    end
  endtask

  task automatic do_redirect(input logic [31:0] target);
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = target;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  initial begin : main_proc
    logic [31:0] saved_pc;
    int sz, k;
    reset_n = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < 128; i++) mem16[i] = 16'($urandom);
    mem16[0] = 16'h0093; mem16[1] = 16'h0020;
    mem16[2] = 16'h4529; mem16[3] = 16'h0593;
    mem16[4] = 16'h0050; mem16[5] = 16'h061d;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Known program start.
`ifdef COMPRESSED_EN
    wait_log(4, "first_instrs");
    check("pc0",  log_pc_at(0),  32'h0);  check("ins0", log_ins_at(0), {1'b0, 32'h0020_0093});
    check("pc1",  log_pc_at(1),  32'h4);  check("ins1", log_ins_at(1), {1'b1, 32'h0000_4529});
    check("pc2",  log_pc_at(2),  32'h6);  check("ins2", log_ins_at(2), {1'b0, 32'h0050_0593});
    check("pc3",  log_pc_at(3),  32'hA);  check("ins3", log_ins_at(3), {1'b1, 32'h0000_061d});
`else
    wait_log(3, "first_instrs");
    check("pc0",  log_pc_at(0),  32'h0);  check("ins0", log_ins_at(0), {1'b0, 32'h0020_0093});
    check("pc1",  log_pc_at(1),  32'h4);  check("ins1", log_ins_at(1), {1'b0, 32'h0593_4529});
    check("pc2",  log_pc_at(2),  32'h8);  check("ins2", log_ins_at(2), {1'b0, 32'h061d_0050});
`endif

    // Back-pressure: buffer fills, requests stop, nothing lost on release.
    @(posedge clk); #1 instr_ready = 1'b0;
    @(negedge clk); saved_pc = instr_pc;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("stall_mem_req", mem_req, 1'b0);
    check("stall_valid", instr_valid, 1'b1);
    check("stall_pc", instr_pc, saved_pc);
    sz = log_pc.size();
    @(posedge clk); #1 instr_ready = 1'b1;
    wait_log(sz + 1, "stall_release");
    check("stall_release_pc", log_pc_at(sz), saved_pc);

    // Redirect while a request is in flight.
    k = 0;
    while (!mem_req && k < 20) begin @(negedge clk); k++; end
    check("req_seen", mem_req, 1'b1);
    do_redirect(32'h0000_0014);
    sz = log_pc.size();
    wait_log(sz + 1, "redirect_14");
    check("redirect_14_pc", log_pc_at(sz), 32'h14);

    // Redirect to a halfword-aligned target.
    do_redirect(32'h0000_0006);
    @(negedge clk);
    check("flush_req", mem_req, 1'b1);
`ifdef COMPRESSED_EN
    check("flush_addr", mem_addr, 32'h6);
`else
    check("flush_addr", mem_addr, 32'h4);
`endif
    sz = log_pc.size();
    wait_log(sz + 1, "redirect_6");
`ifdef COMPRESSED_EN
    check("redirect_6_pc", log_pc_at(sz), 32'h6);
`else
    check("redirect_6_pc", log_pc_at(sz), 32'h4);
`endif

    // Wrap across the top of the address space.
    do_redirect(32'hFFFF_FFFC);
    sz = log_pc.size();
    wait_log(sz + 3, "wrap");
    check("wrap_pc", log_pc_at(sz), 32'hFFFF_FFFC);
    check("wrap_next_pc", log_pc_at(sz + 1), exp_at(32'hFFFF_FFFC) >> 32 ? 32'hFFFF_FFFE : 32'h0);

    // Reset mid-stream.
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 check("async_reset", {mem_req, instr_valid, instr_compressed, mem_addr, instr, instr_pc},
             {3'b000, BOOT, 32'h0000_0000, BOOT});
    repeat (2) @(posedge clk);
    sz = log_pc.size();
    #1 reset_n = 1'b1;
    wait_log(sz + 1, "post_reset");
    check("post_reset_pc", log_pc_at(sz), BOOT);

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      instr_ready    = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = $urandom;
      reset_n        = !((cyc % 1000) == 999);
    end
    @(posedge clk); #1;
    reset_n = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0;
    repeat (10) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_aligner.md
FETCH_ALIGNER -- requirements
Module: fetch_aligner

Interface
REQ-001 Parameter: BOOT_ADDR, default 32'h0000_0000, first fetch byte address after reset.
REQ-002 Parameter: BUF_HW, default 4, halfword buffer depth; fixed at 4, other values unsupported.
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset_n  input  1  asynchronous active-low reset.
REQ-006 Port: mem_req  output  1  read request to program memory this cycle.
REQ-007 Port: mem_addr  output  32  byte address of the read, bit0 always 0.
REQ-008 Port: mem_rdata  input  32  {halfword at addr+2, halfword at addr}, valid exactly one cycle after mem_req.
REQ-009 Port: redirect_valid  input  1  branch/jump redirect strobe.
REQ-010 Port: redirect_pc  input  32  redirect target byte address.
REQ-011 Port: instr_valid  output  1  instr/instr_pc hold a complete instruction.
REQ-012 Port: instr_ready  input  1  decode accepts the instruction.
REQ-013 Port: instr  output  32  instruction; 16-bit instructions zero-extended.
REQ-014 Port: instr_pc  output  32  byte address of instr.
REQ-015 Port: instr_compressed  output  1  instr is 16-bit.

Function
REQ-016 FSM states IDLE, RUN, FLUSH; IDLE -> RUN after one cycle; RUN -> FLUSH on redirect_valid; FLUSH -> RUN after one cycle; reset -> IDLE.
REQ-017 In RUN, mem_req=1 at fetch_pc when (buffered halfwords + 2 per in-flight request) <= BUF_HW-2; on issue, fetch_pc += 4.
REQ-018 The response one cycle after mem_req SHALL push 2 halfwords (low halfword first) into the buffer.
REQ-019 Head halfword bits[1:0]!=2'b11 -> 16-bit instruction, valid when count>=1; otherwise 32-bit {hw1,hw0}, valid when count>=2.
REQ-020 On instr_valid && instr_ready: pop 1 halfword (16-bit) or 2 (32-bit); instr_pc advances by 2 or 4.
REQ-021 Outputs SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-022 A 32-bit instruction split across two memory responses SHALL wait in the buffer until both halves arrive; no partial output.
REQ-023 On redirect_valid: flush the buffer, discard any in-flight response, load fetch_pc and instr_pc with {redirect_pc[31:1],1'b0}, and drive instr_valid=0 the following cycle; the first new request issues in FLUSH.
REQ-024 redirect_valid in the same cycle as a handshake: the handshake completes, then the redirect wins and no further old-path instruction is produced.
REQ-025 Simultaneous push and pop in one cycle SHALL be supported; count never exceeds BUF_HW.
REQ-026 fetch_pc and instr_pc SHALL wrap modulo 2^32 without error.

Reset
REQ-027 While reset_n=0: mem_req=0, mem_addr=BOOT_ADDR, instr_valid=0, instr=0, instr_pc=BOOT_ADDR, instr_compressed=0, buffer empty, state IDLE.
REQ-028 Reset asserted mid-operation SHALL drop the in-flight response; fetch restarts from BOOT_ADDR.

Configuration
REQ-029 Macro COMPRESSED_EN defined: behaviour per REQ-019/020 (RV32C realignment).
REQ-030 COMPRESSED_EN undefined: every instruction is 32-bit, instr_compressed tied 0, pop always 2, redirect and fetch addresses forced to {addr[31:2],2'b00}.

Verification
REQ-031 Memory word0=32'h0020_0093, instr_ready=1 after reset -> first output instr=32'h0020_0093, pc=0, compressed=0.
REQ-032 word4=32'h0593_4529, word8=32'h061d_0050 -> pc=4 instr=32'h0000_4529 compressed=1; pc=6 instr=32'h0050_0593 compressed=0; pc=10 instr=32'h0000_061d compressed=1.
REQ-033 instr_ready=0 for 10 cycles -> mem_req deasserts once the buffer is full; instr/instr_pc unchanged; no halfword lost on release.
REQ-034 redirect_valid with redirect_pc=32'h0000_0014 while a request is in flight -> stale data dropped; next output instr_pc=32'h14.
REQ-035 redirect_pc=32'h0000_0006 with COMPRESSED_EN undefined -> next fetch mem_addr=32'h4, instr_pc=32'h4.
REQ-036 reset_n pulsed low mid-stream -> outputs match REQ-027 immediately; first post-reset instr_pc=BOOT_ADDR.
